// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
// Shared types and constants for the skid-buffered pipeline stage.
//   state_e     : occupancy state of the stage (EMPTY / ONE / TWO); the
//                 encoding equals the number of entries held
//   NOP_INSTR   : bubble instruction presented when NOP injection is built in
//   DEF_*_W     : default field widths
//   occ_of()    : maps a state to its 2-bit occupancy count
// ---------------------------------------------------------------------------
package pipe_pkg;

    localparam int DEF_INSTR_W = 16;
    localparam int DEF_PC_W    = 16;

    localparam logic [15:0] NOP_INSTR = 16'h0800;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

    function automatic logic [1:0] occ_of(input state_e s);
        logic [1:0] occ;
        case (s)
            ONE:     occ = 2'd1;
            TWO:     occ = 2'd2;
            default: occ = 2'd0;
        endcase
        return occ;
    endfunction

endpackage

// File: rtl/pipe_entry.sv
// ---------------------------------------------------------------------------
// pipe_entry
// One storage slot of the pipeline stage: a W-bit register with a
// synchronous clear (highest priority) and a load enable.
// Ports:
//   clk    : clock
//   clr_i  : synchronous clear, forces contents to zero
//   load_i : capture d_i at the rising edge
//   d_i    : data to capture
//   q_o    : stored contents
// ---------------------------------------------------------------------------
module pipe_entry #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         clr_i,
    input  logic         load_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] data_q;

    always_ff @(posedge clk) begin
        if (clr_i) begin
            data_q <= '0;
        end else if (load_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// ---------------------------------------------------------------------------
// pipe_stage_skid
// Pipeline register between two stages carrying {instruction, incremented PC}
// with a valid/ready handshake and a 2-entry skid buffer. in_ready is derived
// only from registered state and freeze, so no combinational ready path runs
// from downstream to upstream.
//
// Ports:
//   clk, global_rst      : clock, synchronous active-high reset
//   local_clr            : synchronous flush, same effect as reset
//   freeze               : stall; blocks both handshakes, holds all state
//   in_valid / in_ready  : upstream handshake
//   instr_in, inc_PC_in  : upstream payload
//   out_valid / out_ready: downstream handshake
//   instr_out, inc_PC_out: main-entry payload (qualify with out_valid)
//   occupancy            : number of held entries (0..2)
//
// Build option: define PIPE_NOP_INJECT_EN to force instr_out to NOP_INSTR
// whenever out_valid is low; otherwise instr_out is the raw main entry.
// ---------------------------------------------------------------------------
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int INSTR_W = DEF_INSTR_W,
    parameter int PC_W    = DEF_PC_W
) (
    input  logic               clk,
    input  logic               global_rst,
    input  logic               local_clr,
    input  logic               freeze,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] instr_in,
    input  logic [PC_W-1:0]    inc_PC_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] instr_out,
    output logic [PC_W-1:0]    inc_PC_out,
    output logic [1:0]         occupancy
);

    localparam int ENTRY_W = INSTR_W + PC_W;

    state_e state_q, state_d;

    logic               clr;
    logic               in_fire;
    logic               out_fire;
    logic               main_load;
    logic               main_from_skid;
    logic               skid_load;
    logic [ENTRY_W-1:0] in_entry;
    logic [ENTRY_W-1:0] main_d;
    logic [ENTRY_W-1:0] main_q;
    logic [ENTRY_W-1:0] skid_q;
    logic [INSTR_W-1:0] main_instr;

    // Clear wins over freeze: a flush always empties the stage.
    assign clr = global_rst | local_clr;

    assign in_ready  = (state_q != TWO)   & ~freeze;
    assign out_valid = (state_q != EMPTY) & ~freeze;
    assign in_fire   = in_valid  & in_ready;
    assign out_fire  = out_valid & out_ready;

    assign in_entry = {instr_in, inc_PC_in};

    always_comb begin
        state_d        = state_q;
        main_load      = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    main_load = 1'b1;
                    state_d   = ONE;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    main_load = 1'b1;
                end else if (in_fire) begin
                    // Downstream stalled: park the new word behind the main one.
                    skid_load = 1'b1;
                    state_d   = TWO;
                end else if (out_fire) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                // in_ready is low here, so only the drain path can happen.
                if (out_fire) begin
                    main_load      = 1'b1;
                    main_from_skid = 1'b1;
                    state_d        = ONE;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    assign main_d = main_from_skid ? skid_q : in_entry;

    pipe_entry #(.W(ENTRY_W)) u_main (
        .clk    (clk),
        .clr_i  (clr),
        .load_i (main_load),
        .d_i    (main_d),
        .q_o    (main_q)
    );

    pipe_entry #(.W(ENTRY_W)) u_skid (
        .clk    (clk),
        .clr_i  (clr),
        .load_i (skid_load),
        .d_i    (in_entry),
        .q_o    (skid_q)
    );

    assign main_instr = main_q[ENTRY_W-1:PC_W];
    assign inc_PC_out = main_q[PC_W-1:0];
    assign occupancy  = occ_of(state_q);

`ifdef PIPE_NOP_INJECT_EN
    localparam logic [INSTR_W-1:0] NOP_W = INSTR_W'(NOP_INSTR);
    assign instr_out = out_valid ? main_instr : NOP_W;
`else
    assign instr_out = main_instr;
`endif

endmodule
